// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 convolution controller.
// Holds the FSM state enum, kernel size, line-buffer slot width and
// the default frame geometry / datapath latency.
package conv_pkg;

    localparam int K            = 3;
    localparam int SLOT_W       = 2;
    localparam int DEF_IFM_ROWS = 16;
    localparam int DEF_IFM_COLS = 16;
    localparam int DEF_MAC_LAT  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_CALC  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    // Advance a line-buffer slot index, wrapping K-1 back to 0.
    function automatic logic [SLOT_W-1:0] slot_inc(input logic [SLOT_W-1:0] s);
        return (s == SLOT_W'(K - 1)) ? '0 : s + SLOT_W'(1);
    endfunction

endpackage

// File: rtl/conv_ctrl_vpipe.sv
// Valid-bit delay line matching the MAC datapath latency.
// A reset clears every stage so in-flight results never surface.
module conv_ctrl_vpipe #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic vld_i,
    output logic vld_o
);

    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;

    generate
        if (DEPTH == 1) begin : g_one
            assign sr_d = vld_i;
        end else begin : g_many
            assign sr_d = {sr_q[DEPTH-2:0], vld_i};
        end
    endgenerate

    // Shift the valid bit one stage per clock; synchronous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign vld_o = sr_q[DEPTH-1];

endmodule

// File: rtl/conv_ctrl.sv
// Control FSM for a 3x3 convolution engine over a 3-row line buffer.
// Loads one kernel beat, streams IFM rows into rotating slots, and issues
// one calc_en per output column for every 3-row window of the frame.
// Optional build macro CONV_CTRL_PERF_EN adds a perf_cycles frame counter.
module conv_ctrl
    import conv_pkg::*;
#(
    parameter int IFM_ROWS = DEF_IFM_ROWS,
    parameter int IFM_COLS = DEF_IFM_COLS,
    parameter int MAC_LAT  = DEF_MAC_LAT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        weight_valid,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        wgt_ld_en,
    output logic        lb_wr_en,
    output logic [1:0]  lb_wr_sel,
    output logic [1:0]  row_base,
    output logic        calc_en,
    output logic [3:0]  col_idx,
    output logic        out_valid,
    output logic        frame_done,
    output logic        err_drop
`ifdef CONV_CTRL_PERF_EN
    ,
    output logic [15:0] perf_cycles
`endif
);

    localparam int RW       = $clog2(IFM_ROWS + 1);
    localparam int LAST_COL = IFM_COLS - K;

    state_e            state_q, state_d;
    logic [RW-1:0]     rows_q, rows_d;
    logic [SLOT_W-1:0] wr_q, wr_d;
    logic [SLOT_W-1:0] base_q, base_d;
    logic [3:0]        col_q, col_d;
    logic [7:0]        drain_q, drain_d;
    logic              err_q, err_d;

    // Next-state, counters and strobes; outputs default low.
    always_comb begin
        state_d    = state_q;
        rows_d     = rows_q;
        wr_d       = wr_q;
        base_d     = base_q;
        col_d      = col_q;
        drain_d    = drain_q;
        in_ready   = 1'b0;
        wgt_ld_en  = 1'b0;
        lb_wr_en   = 1'b0;
        calc_en    = 1'b0;
        frame_done = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (weight_valid) begin
                    // Gated so a kernel beat seen during reset is never reported as loaded.
                    wgt_ld_en = rst_n;
                    rows_d    = '0;
                    wr_d      = '0;
                    base_d    = '0;
                    col_d     = '0;
                    state_d   = ST_FILL;
                end
            end
            ST_FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    lb_wr_en = 1'b1;
                    wr_d     = slot_inc(wr_q);
                    rows_d   = (rows_q == RW'(IFM_ROWS)) ? rows_q : rows_q + RW'(1);
                    // First window needs three rows; afterwards each new row opens a window.
                    if (rows_d >= RW'(K)) begin
                        col_d   = '0;
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                calc_en = 1'b1;
                if (col_q == 4'(LAST_COL)) begin
                    if (rows_q == RW'(IFM_ROWS)) begin
                        drain_d = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        base_d  = slot_inc(base_q);
                        state_d = ST_FILL;
                    end
                end else begin
                    col_d = col_q + 4'd1;
                end
            end
            ST_DRAIN: begin
                // The last result leaves the datapath MAC_LAT cycles after the final calc_en.
                if (drain_q == 8'(MAC_LAT - 1)) begin
                    frame_done = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    drain_d = drain_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        err_d = (in_valid && !in_ready) || (weight_valid && (state_q != ST_IDLE));
    end

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rows_q  <= '0;
            wr_q    <= '0;
            base_q  <= '0;
            col_q   <= '0;
            drain_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rows_q  <= rows_d;
            wr_q    <= wr_d;
            base_q  <= base_d;
            col_q   <= col_d;
            drain_q <= drain_d;
            err_q   <= err_d;
        end
    end

    assign lb_wr_sel = wr_q;
    assign row_base  = base_q;
    assign col_idx   = calc_en ? col_q : 4'd0;
    assign err_drop  = err_q;

    conv_ctrl_vpipe #(
        .DEPTH (MAC_LAT)
    ) u_vpipe (
        .clk   (clk),
        .rst_n (rst_n),
        .vld_i (calc_en),
        .vld_o (out_valid)
    );

`ifdef CONV_CTRL_PERF_EN
    logic [15:0] perf_q, perf_d;
    logic        prun_q, prun_d;

    // Frame cycle counter: starts at the kernel load, stops after frame_done, then holds.
    always_comb begin
        perf_d = perf_q;
        prun_d = prun_q;
        if (wgt_ld_en) begin
            perf_d = 16'd1;
            prun_d = 1'b1;
        end else if (prun_q) begin
            if (perf_q != 16'hFFFF) begin
                perf_d = perf_q + 16'd1;
            end
            if (frame_done) begin
                prun_d = 1'b0;
            end
        end
    end

    // Counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_q <= '0;
            prun_q <= 1'b0;
        end else begin
            perf_q <= perf_d;
            prun_q <= prun_d;
        end
    end

    assign perf_cycles = perf_q;
`else
    // Default build: no performance counter.
`endif

endmodule

// File: tb/tb_conv_ctrl.sv
// Scoreboard bench for conv_ctrl: expected window/row/output events are queued
// per frame from the frame geometry; a negedge monitor pops and compares.
module tb_conv_ctrl;

    localparam int ROWS = 16;
    localparam int COLS = 16;
    localparam int LAT  = 2;
    localparam int WIN  = COLS - 2;
    localparam int OUTS = (ROWS - 2) * (COLS - 2);

    logic       clk;
    logic       rst_n;
    logic       weight_valid;
    logic       in_valid;
    logic       in_ready;
    logic       wgt_ld_en;
    logic       lb_wr_en;
    logic [1:0] lb_wr_sel;
    logic [1:0] row_base;
    logic       calc_en;
    logic [3:0] col_idx;
    logic       out_valid;
    logic       frame_done;
    logic       err_drop;
`ifdef CONV_CTRL_PERF_EN
    logic [15:0] perf_cycles;
`endif

    conv_ctrl #(
        .IFM_ROWS (ROWS),
        .IFM_COLS (COLS),
        .MAC_LAT  (LAT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .weight_valid (weight_valid),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .wgt_ld_en    (wgt_ld_en),
        .lb_wr_en     (lb_wr_en),
        .lb_wr_sel    (lb_wr_sel),
        .row_base     (row_base),
        .calc_en      (calc_en),
        .col_idx      (col_idx),
        .out_valid    (out_valid),
        .frame_done   (frame_done),
        .err_drop     (err_drop)
`ifdef CONV_CTRL_PERF_EN
        ,
        .perf_cycles  (perf_cycles)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    int exp_calc[$];
    int exp_wr[$];
    int exp_last[$];

    int wgt_seen   = 0;
    int err_seen   = 0;
    int outs_seen  = 0;
    int calcs_seen = 0;
    int wr_seen    = 0;
    logic [7:0] calc_hist = '0;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every DUT event against the queued expectations.
    initial begin
        int e;
        forever begin
            @(negedge clk);
            if (wgt_ld_en) begin
                wgt_seen++;
                calcs_seen = 0;
                wr_seen    = 0;
            end
            if (err_drop) err_seen++;
            if (lb_wr_en) begin
                e = (wr_seen < 3) ? 0 : (wr_seen - 2) * WIN;
                chk(calcs_seen == e, "row_accept_order", calcs_seen, e);
                if (exp_wr.size() == 0) begin
                    chk(1'b0, "unexpected_lb_wr_en", int'(lb_wr_sel), -1);
                end else begin
                    e = exp_wr.pop_front();
                    chk(int'(lb_wr_sel) == e, "lb_wr_sel", int'(lb_wr_sel), e);
                end
                wr_seen++;
            end
            if (calc_en) begin
                if (exp_calc.size() == 0) begin
                    chk(1'b0, "unexpected_calc_en", int'(col_idx), -1);
                end else begin
                    e = exp_calc.pop_front();
                    chk(int'(row_base) * 16 + int'(col_idx) == e, "row_base_col_idx",
                        int'(row_base) * 16 + int'(col_idx), e);
                end
                calcs_seen++;
            end
            if (out_valid) begin
                chk(calc_hist[LAT-1] == 1'b1, "out_valid_latency", int'(calc_hist[LAT-1]), 1);
                if (exp_last.size() == 0) begin
                    chk(1'b0, "unexpected_out_valid", 1, 0);
                end else begin
                    e = exp_last.pop_front();
                    chk(int'(frame_done) == e, "frame_done_align", int'(frame_done), e);
                end
                outs_seen++;
            end else if (frame_done) begin
                chk(1'b0, "frame_done_without_out_valid", 1, 0);
            end
            calc_hist = {calc_hist[6:0], calc_en};
        end
    end

    task automatic reset_check(input string tag);
        chk(in_ready   == 1'b0, {tag, "_in_ready"},   int'(in_ready), 0);
        chk(wgt_ld_en  == 1'b0, {tag, "_wgt_ld_en"},  int'(wgt_ld_en), 0);
        chk(lb_wr_en   == 1'b0, {tag, "_lb_wr_en"},   int'(lb_wr_en), 0);
        chk(lb_wr_sel  == 2'd0, {tag, "_lb_wr_sel"},  int'(lb_wr_sel), 0);
        chk(row_base   == 2'd0, {tag, "_row_base"},   int'(row_base), 0);
        chk(calc_en    == 1'b0, {tag, "_calc_en"},    int'(calc_en), 0);
        chk(col_idx    == 4'd0, {tag, "_col_idx"},    int'(col_idx), 0);
        chk(out_valid  == 1'b0, {tag, "_out_valid"},  int'(out_valid), 0);
        chk(frame_done == 1'b0, {tag, "_frame_done"}, int'(frame_done), 0);
        chk(err_drop   == 1'b0, {tag, "_err_drop"},   int'(err_drop), 0);
`ifdef CONV_CTRL_PERF_EN
        chk(perf_cycles == 16'd0, {tag, "_perf_cycles"}, int'(perf_cycles), 0);
`endif
    endtask

    // One frame: kernel beat, 16 rows with gaps, optional spurious kernel beat,
    // optional reset once abort_outs outputs have been seen.
    task automatic run_frame(input int gap_lo, input int gap_hi, input bit ready_aware,
                             input bit hold, input int spur_row, input int abort_outs);
        int  rows, gap_left, cyc, err_exp, err0, wgt0, outs0, outs_after;
        bit  rdy, fd, iv, wv, spurred, done;
        for (int r = 0; r < ROWS - 2; r++) begin
            for (int c = 0; c < WIN; c++) begin
                exp_calc.push_back((r % 3) * 16 + c);
                exp_last.push_back((r == ROWS - 3 && c == WIN - 1) ? 1 : 0);
            end
        end
        for (int r = 0; r < ROWS; r++) exp_wr.push_back(r % 3);
        err0 = err_seen; wgt0 = wgt_seen; outs0 = outs_seen;
        err_exp = 0; rows = 0; spurred = 0; done = 0;
        gap_left = $urandom_range(gap_hi, gap_lo);

        @(posedge clk); #1;
        weight_valid = 1'b1;
        in_valid     = 1'b0;
        cyc = 1;
        for (int k = 0; k < 3000 && !done; k++) begin
            @(posedge clk); #1;
            weight_valid = 1'b0;
            cyc++;
            if (abort_outs >= 0 && outs_seen - outs0 >= abort_outs) begin
                rst_n = 1'b0;
                in_valid = 1'b0;
                @(posedge clk); #1;
                reset_check("midframe_reset");
                exp_calc.delete(); exp_wr.delete(); exp_last.delete();
                rst_n = 1'b1;
                outs_after = outs_seen;
                repeat (30) @(posedge clk);
                #1;
                chk(outs_seen == outs_after, "no_out_valid_after_reset", outs_seen - outs_after, 0);
                return;
            end
            rdy = in_ready;
            fd  = frame_done;
            iv  = 1'b0;
            if (rows < ROWS) begin
                if (gap_left > 0) gap_left--;
                else iv = ready_aware ? rdy : 1'b1;
            end else if (hold) begin
                iv = 1'b1;
            end
            wv = (spur_row >= 0) && (rows == spur_row) && !spurred && iv && rdy;
            in_valid     = iv;
            weight_valid = wv;
            if ((iv && !rdy) || wv) err_exp++;
            if (iv && rdy) begin
                rows++;
                gap_left = $urandom_range(gap_hi, gap_lo);
            end
            if (wv) begin
                spurred = 1'b1;
                #1;
                chk(wgt_ld_en == 1'b0, "spurious_weight_wgt_ld_en", int'(wgt_ld_en), 0);
            end
            if (fd) done = 1'b1;
        end
        chk(done, "frame_done_timeout", int'(done), 1);

        @(posedge clk); #1;
        in_valid     = 1'b0;
        weight_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk(outs_seen - outs0 == OUTS, "outputs_per_frame", outs_seen - outs0, OUTS);
        chk(exp_calc.size() == 0, "calc_queue_empty", exp_calc.size(), 0);
        chk(exp_wr.size() == 0, "row_queue_empty", exp_wr.size(), 0);
        chk(wgt_seen - wgt0 == 1, "wgt_ld_en_per_frame", wgt_seen - wgt0, 1);
        chk(err_seen - err0 == err_exp, "err_drop_count", err_seen - err0, err_exp);
        if (hold) chk(err_seen - err0 == OUTS + LAT, "hold_err_total", err_seen - err0, OUTS + LAT);
        if (gap_hi == 0) chk(cyc == 1 + ROWS + OUTS + LAT, "gapless_frame_cycles", cyc, 1 + ROWS + OUTS + LAT);
`ifdef CONV_CTRL_PERF_EN
        chk(int'(perf_cycles) == cyc, "perf_cycles_hold", int'(perf_cycles), cyc);
`endif
    endtask

    initial begin
        rst_n        = 1'b0;
        weight_valid = 1'b0;
        in_valid     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_check("reset");
        rst_n    = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);

        run_frame(0, 0, 1'b1, 1'b0, -1, -1);
        run_frame(0, 0, 1'b0, 1'b1, -1, -1);
        run_frame(0, 3, 1'b1, 1'b0, 4, -1);
        run_frame(1, 1, 1'b0, 1'b0, -1, -1);
        for (int f = 0; f < 2; f++) begin
            run_frame(0, int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)), 1'b0,
                      int'($urandom_range(15, 3)), -1);
        end
        run_frame(0, 0, 1'b0, 1'b1, -1, 50);
        run_frame(0, 2, 1'b1, 1'b0, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/conv_ctrl.md
CONV_CTRL -- requirements
Module: conv_ctrl

Interface
REQ-001 SHALL have parameter IFM_ROWS, default 16, meaning IFM rows per frame (min 3).
REQ-002 SHALL have parameter IFM_COLS, default 16, meaning pixels per row (16 x 8-bit = one 128-bit beat).
REQ-003 SHALL have parameter MAC_LAT, default 2, meaning cycles from calc_en to datapath result.
REQ-004 SHALL have port clk, in, 1, the single clock.
REQ-005 SHALL have port rst_n, in, 1, reset: synchronous, active-low.
REQ-006 SHALL have port weight_valid, in, 1, one 3x3 kernel beat present.
REQ-007 SHALL have port in_valid, in, 1, one IFM row beat present.
REQ-008 SHALL have port in_ready, out, 1, controller accepts an IFM row this cycle.
REQ-009 SHALL have port wgt_ld_en, out, 1, datapath latches In_Weight.
REQ-010 SHALL have port lb_wr_en / lb_wr_sel, out, 1 / 2, line-buffer write strobe and slot 0..2.
REQ-011 SHALL have port row_base, out, 2, slot of the oldest row in the 3-row window.
REQ-012 SHALL have port calc_en / col_idx, out, 1 / 4, compute one output at window column col_idx.
REQ-013 SHALL have port out_valid, out, 1, Out_OFM valid (calc_en delayed MAC_LAT).
REQ-014 SHALL have port frame_done / err_drop, out, 1 / 1, single-cycle pulses.

Function
REQ-015 SHALL implement states IDLE, FILL, CALC, DRAIN.
REQ-016 IDLE: weight_valid -> wgt_ld_en=1 same cycle, row count cleared, wr slot 0, row_base 0, next FILL.
REQ-017 FILL: in_ready=1; in_valid -> lb_wr_en=1, lb_wr_sel=wr slot, wr slot +1 mod 3, rows_in +1.
REQ-018 FILL -> CALC when the accepted row makes rows_in >= 3 (initial fill 3 rows; later refills 1 row).
REQ-019 CALC: in_ready=0, calc_en=1 each cycle, col_idx 0..IFM_COLS-3 (0..13 default), one output per cycle.
REQ-020 After col_idx=IFM_COLS-3: if rows_in == IFM_ROWS -> DRAIN; else row_base +1 mod 3, -> FILL.
REQ-021 DRAIN: wait MAC_LAT cycles until the last out_valid, pulse frame_done with it, -> IDLE.
REQ-022 Per frame exactly (IFM_ROWS-2)*(IFM_COLS-2) out_valid pulses (196 default), in row-major order.
REQ-023 in_valid while in_ready=0 SHALL be ignored and pulse err_drop next cycle.
REQ-024 weight_valid outside IDLE SHALL be ignored and pulse err_drop; new weights only between frames.
REQ-025 weight_valid and in_valid together in IDLE: weight taken, in_valid dropped, err_drop pulsed.
REQ-026 Slot counters SHALL wrap 2 -> 0; rows_in SHALL saturate at IFM_ROWS.

Reset
REQ-027 rst_n=0 at a clock edge SHALL force IDLE, clear all counters and the MAC_LAT valid pipeline, and drive every output 0, including mid-frame; in-flight results are discarded.

Configuration
REQ-028 Macro CONV_CTRL_PERF_EN defined: add output perf_cycles[15:0].
REQ-029 perf_cycles SHALL count clocks from wgt_ld_en up to and including frame_done, hold until the next wgt_ld_en, saturate at 16'hFFFF, and reset to 0.
REQ-030 Without CONV_CTRL_PERF_EN the port and counter SHALL be absent and all other behaviour identical.

Structure
REQ-031 Package conv_pkg SHALL hold the state enum, K=3, the slot width, and the default IFM_ROWS/IFM_COLS/MAC_LAT constants.
REQ-032 Sub-module conv_ctrl_vpipe (MAC_LAT-deep valid shift register with synchronous clear) SHALL generate out_valid.

Verification
REQ-033 Scenario: 1 weight beat, then 16 back-to-back in_valid rows held high -> 196 out_valid, frame_done on the last one, no err_drop.
REQ-034 Scenario: in_valid held high during CALC -> err_drop once per ignored cycle; the 4th row is accepted only after col_idx=13.
REQ-035 Scenario: weight_valid during FILL of row 5 -> err_drop=1, wgt_ld_en=0, frame continues unchanged.
REQ-036 Scenario: rst_n=0 for 1 cycle after 50 outputs -> all outputs 0 next cycle, no further out_valid; a new frame then yields 196.
REQ-037 Scenario: check row_base sequence 0,1,2,0,... across the 14 output rows and lb_wr_sel 0,1,2,0,... across the 16 rows.
REQ-038 Scenario: PERF_EN build, rows with 1 idle cycle between each -> perf_cycles equals the bench-counted cycles and holds after frame_done.
